fir_out_sink: RTL and testbench
===============================

# fir_out_sink

Receiving end of the FIR filter output stream. Accepts the wide, valid-only (no backpressure) accumulator output, rounds and saturates it back to sample width, and buffers the results in a FIFO. Samples leave on a ready/valid stream toward downstream consumers (DAC formatter, decimator, bus bridge). Overflow and clipping are reported through sticky flags and a drop counter, because the filter side cannot be stalled.

## Interface
- IN_WIDTH, 32: width of the signed input sample (filter accumulator width).
- OUT_WIDTH, 16: width of the signed output sample.
- SHIFT, 15: arithmetic right shift applied after rounding (coefficient fraction bits). Range 1..IN_WIDTH-1.
- DEPTH, 8: FIFO entries. Power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_sample  in  IN_WIDTH  signed filter output.
- in_valid  in  1  in_sample is valid this cycle. There is no ready, so every valid sample must be accounted for.
- out_sample  out  OUT_WIDTH  signed head-of-FIFO sample.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the sample.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- clipped  out  1  sticky; a saturation occurred.
- overflow  out  1  sticky; a sample was dropped.
- drop_count  out  16  number of dropped samples; saturates at 0xFFFF.
- clr  in  1  synchronous clear of clipped, overflow and drop_count.

## Operation
- **Stage 1 (register), on a cycle with in_valid=1:**
  - r = (in_sample + 2^(SHIFT-1)) >>> SHIFT, computed at IN_WIDTH+1 bits. This is round-half-up.
  - If r > 2^(OUT_WIDTH-1)-1, the stage holds the maximum value and sets clipped.
  - If r < -2^(OUT_WIDTH-1), the stage holds the minimum value and sets clipped.
  - Otherwise the stage holds r.
  - s1_valid follows in_valid every cycle.
- **Stage 2 (FIFO):**
  - push = s1_valid. pop = out_valid & out_ready.
  - Not full: the push writes mem[wr_ptr], and wr_ptr increments.
  - Full and pop=1: the push still succeeds (simultaneous read and write). level stays DEPTH.
  - Full and pop=0: the sample is discarded. overflow is set, drop_count increments (saturating at 0xFFFF), and FIFO contents are unchanged.
  - Pop while empty is impossible because pop is gated by out_valid.
  - level updates: +1 on push only, −1 on pop only, unchanged on both or neither.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from level.
- **Output:** out_sample = mem[rd_ptr] (show-ahead), and out_valid = (level != 0). out_sample must be stable while out_valid=1 and out_ready=0.
- **Flags:**
  - clr clears clipped, overflow and drop_count.
  - If a new clip or drop occurs in the same cycle as clr, the new event wins: the flag is 1, and drop_count becomes 1 for a drop.
- **Reset:**
  - Outputs: out_sample=0, out_valid=0, level=0, clipped=0, overflow=0, drop_count=0.
  - Internal state: s1_valid=0, pointers=0, memory cleared.
  - An assertion mid-stream discards any in-flight stage-1 sample and all FIFO contents immediately (asynchronous).

## Timing
- **Latency:** in_valid sampled at edge E0 gives out_valid=1 after edge E1 (2 cycles), provided the FIFO was empty and no drop occurred.
- **Throughput:** one sample per cycle in and one sample per cycle out, sustained.
- **Pop:** takes effect at the edge where out_valid & out_ready=1. The next entry, or out_valid=0, is visible after that edge.
- **Flag timing:** clipped is set one edge after the input edge. overflow and drop_count update one edge later, at the FIFO-write edge.
- **Handshake:** out_ready may toggle freely. out_valid never deasserts without a pop, except on reset.

## Test plan
All scenarios use default parameters unless stated.
1. **Rounding.** in_sample = 3276800, 16384, 16383, −16384, −16385, with out_ready=1. Required response:
   - out_sample = 100, 1, 0, 0, −1, in order.
   - Each sample appears 2 cycles after its input.
   - clipped stays 0.
2. **Saturation.** in_sample = 0x7FFFFFFF, then 0x80000000. Required response:
   - out_sample = 32767, then −32768.
   - clipped=1.
   - Asserting clr afterwards returns clipped to 0.
3. **Overflow.** out_ready=0; send 10 consecutive samples with values 1..10, each scaled by 32768. Required response:
   - level=8, overflow=1, drop_count=2.
   - After setting out_ready=1, outputs are 1..8 in order, then out_valid=0.
4. **Simultaneous push and pop at full.** Fill the FIFO to 8, then drive continuous input with out_ready=1. Required response:
   - level stays 8, and drop_count is unchanged.
   - Output order is preserved across pointer wrap-around.
5. **Backpressure stability.** Toggle out_ready randomly while driving a 1-cycle-on / 1-cycle-off input stream. Required response:
   - out_sample is stable while stalled.
   - No loss and no duplication; the output sequence equals the input sequence.
6. **Reset mid-stream.** Assert rst with level=5 and a sample in stage 1. Required response:
   - Immediately: out_valid=0, level=0, flags and drop_count = 0.
   - The first post-reset input appears after 2 cycles.

Source files
------------

// File: rtl/fir_out_sink.sv
// fir_out_sink: round/saturate wide FIR output to sample width and buffer it in a show-ahead FIFO
// Ports: in_sample/in_valid wide valid-only input; out_sample/out_valid/out_ready output stream;
//        level FIFO occupancy; clipped/overflow sticky flags; drop_count saturating drop tally;
//        clr synchronous clear of flags and drop_count; rst asynchronous active-high.
module fir_out_sink #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      in_sample,
  input  logic                     in_valid,
  output logic [OUT_WIDTH-1:0]     out_sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     clipped,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  input  logic                     clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic signed [IN_WIDTH:0] RND = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
  logic signed [IN_WIDTH:0] sum, r;
  logic hi, lo, full, pop, wr_en, drop, s1_valid;
  logic [OUT_WIDTH-1:0] sat, s1_sample;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_comb begin
    // one extra bit so adding the rounding constant can never wrap
    sum = $signed({in_sample[IN_WIDTH-1], in_sample}) + RND;
    r = sum >>> SHIFT;
    hi = r > MAXV;
    lo = r < MINV;
    sat = hi ? MAXV[OUT_WIDTH-1:0] : lo ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
    out_valid = level != '0;
    out_sample = mem[rd_ptr];
    full = level == FULL;
    pop = out_valid & out_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    wr_en = s1_valid & (~full | pop);
    drop = s1_valid & full & ~pop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sample <= '0;
      clipped <= 1'b0;
      overflow <= 1'b0;
      drop_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_sample <= sat;
      // a new event in the clr cycle takes precedence over the clear
      clipped <= (in_valid & (hi | lo)) | (clipped & ~clr);
      overflow <= drop | (overflow & ~clr);
      drop_count <= drop ? (clr ? 16'd1 : drop_count + {15'd0, ~&drop_count}) : clr ? '0 : drop_count;
      if (wr_en) begin
        mem[wr_ptr] <= s1_sample;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(pop);
    end
  end
endmodule

// File: tb/tb_fir_out_sink.sv
// tb_fir_out_sink: randomized scoreboard bench for fir_out_sink against a cycle-level reference model
module tb_fir_out_sink;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [31:0] in_sample = '0;
  logic in_valid = 1'b0;
  logic signed [15:0] out_sample;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [3:0] level;
  logic clipped, overflow;
  logic [15:0] drop_count;
  logic clr = 1'b0;
  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int mlevel = 0;
  bit mclip = 0, movf = 0;
  int mdrop = 0;
  bit s1v = 0;
  int s1d = 0;
  bit prev_stall = 0;
  logic signed [15:0] prev_sample;

  fir_out_sink dut (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .clipped(clipped), .overflow(overflow),
    .drop_count(drop_count), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // round half up as floor((x + 2^14) / 2^15), then clamp to 16-bit signed
  function automatic int ref_round(input longint x, output bit clip);
    longint t, q;
    t = x + 16384;
    q = (t < 0) ? -((-t + 32767) / 32768) : t / 32768;
    clip = (q > 32767) || (q < -32768);
    return (q > 32767) ? 32767 : (q < -32768) ? -32768 : int'(q);
  endfunction

  // reference model: stage register plus an 8-deep FIFO occupancy, updated per clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      mlevel = 0; mclip = 0; movf = 0; mdrop = 0; s1v = 0; s1d = 0;
    end else begin
      bit pop, c;
      int v;
      pop = (mlevel > 0) && out_ready;
      if (clr) begin mclip = 0; movf = 0; mdrop = 0; end
      if (s1v) begin
        if (mlevel < 8 || pop) begin
          exp_q.push_back(s1d);
          mlevel++;
        end else begin
          movf = 1;
          if (mdrop < 65535) mdrop++;
        end
      end
      if (pop) mlevel--;
      s1v = in_valid;
      if (in_valid) begin
        v = ref_round(longint'(in_sample), c);
        s1d = v;
        if (c) mclip = 1;
      end
    end
  end

  // monitor: per-cycle state checks and scoreboard pops on handshake
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      chk("level", level, mlevel);
      chk("out_valid", out_valid, mlevel != 0);
      chk("clipped", clipped, mclip);
      chk("overflow", overflow, movf);
      chk("drop_count", drop_count, mdrop);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_stable", out_sample, prev_sample);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", out_sample, -99999);
        else chk("out_sample", out_sample, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_sample = out_sample;
    end
  end

  task automatic step(input bit v, input logic signed [31:0] d, input bit rdy, input bit c);
    @(posedge clk); #1;
    in_valid = v; in_sample = d; out_ready = rdy; clr = c;
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_level", level, 0);
    chk("rst_flags", {clipped, overflow}, 0);
    chk("rst_drop", drop_count, 0);
    @(posedge clk); #3 rst = 1'b0;
    // rounding
    step(1, 3276800, 1, 0);
    step(1, 16384, 1, 0);
    step(1, 16383, 1, 0);
    step(1, -16384, 1, 0);
    step(1, -16385, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    chk("round_noclip", clipped, 0);
    // saturation then clear
    step(1, 32'h7FFFFFFF, 1, 0);
    step(1, 32'h80000000, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    @(negedge clk);
    chk("sat_clipped", clipped, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    @(negedge clk);
    chk("clr_clipped", clipped, 0);
    // overflow: ten samples into a stalled 8-deep FIFO
    for (int k = 1; k <= 10; k++) step(1, k * 32768, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 2);
    repeat (12) step(0, 0, 1, 0);
    @(negedge clk);
    chk("ovf_drained", out_valid, 0);
    chk("ovf_queue_empty", exp_q.size(), 0);
    // full FIFO with simultaneous push and pop across pointer wrap
    for (int k = 11; k <= 19; k++) step(1, k * 32768, 0, 0);
    for (int k = 20; k <= 40; k++) step(1, k * 32768, 1, 0);
    @(negedge clk);
    chk("full_level", level, 8);
    chk("full_drops", drop_count, 2);
    repeat (12) step(0, 0, 1, 0);
    // random backpressure with a half-rate input stream
    for (int i = 0; i < 300; i++)
      step(i % 2 == 0, $signed($urandom) >>> $urandom_range(0, 18), $urandom_range(0, 3) != 0, 0);
    repeat (15) step(0, 0, 1, 0);
    @(negedge clk);
    chk("rand_queue_empty", exp_q.size(), 0);
    // reset mid-stream with level 5 and one sample in stage 1
    step(1, 32'h7FFFFFFF, 0, 0);
    for (int k = 2; k <= 6; k++) step(1, k * 32768, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_level", level, 5);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_flags", {clipped, overflow}, 0);
    chk("mid_rst_drop", drop_count, 0);
    @(posedge clk); #3 rst = 1'b0;
    step(1, 7 * 32768, 1, 0);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lat1", out_valid, 0);
    @(negedge clk);
    chk("post_rst_lat2", out_valid, 1);
    chk("post_rst_sample", out_sample, 7);
    repeat (4) step(0, 0, 1, 0);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
